// File: rtl/fp_round_pack_pipe.sv
// Two-stage IEEE-754 round-and-pack with RISC-V rounding modes and fflags.
// Stage 1 decides the rounding direction and special class; stage 2 increments, checks overflow and packs.
module fp_round_pack_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int GRS_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W:0]           in_exp,
  input  logic [MAN_W-1:0]         in_man,
  input  logic [GRS_W-1:0]         in_grs,
  input  logic                     in_uflow,
  input  logic                     in_nan,
  input  logic                     in_invalid,
  input  logic                     in_inf,
  input  logic [2:0]               in_rm,
  input  logic [2:0]               frm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [4:0]               out_fflags
);

  localparam int RES_W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W:0]     EXP_TOP = {1'b0, {EXP_W{1'b1}}};
  localparam logic [RES_W-1:0]   QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [4:0] FLG_NV    = 5'b10000;
  localparam logic [4:0] FLG_OFNX  = 5'b00101;
  localparam logic [4:0] FLG_UFNX  = 5'b00011;

  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   exp;
    logic [MAN_W-1:0] man;
    logic [2:0]       rm;
    logic             up;
    logic             inx;
    logic             illegal;
    logic             invalid;
    logic             nan;
    logic             inf;
    logic             ovf;
    logic             uflow;
  } s1_t;

  function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                    input logic g, input logic r, input logic s,
                                    input logic lsb);
    logic inx;
    inx = g | r | s;
    case (rm)
      RM_RNE:  round_up = g & (r | s | lsb);
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = sign & inx;
      RM_RUP:  round_up = ~sign & inx;
      RM_RMM:  round_up = g;
      default: round_up = 1'b0;
    endcase
  endfunction

  // Directed rounding saturates to max finite when rounding toward zero magnitude.
  function automatic logic [RES_W-1:0] ovf_result(input logic [2:0] rm, input logic sign);
    logic [RES_W-1:0] inf_v;
    logic [RES_W-1:0] max_v;
    inf_v = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    max_v = {sign, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
    case (rm)
      RM_RTZ:  ovf_result = max_v;
      RM_RDN:  ovf_result = sign ? inf_v : max_v;
      RM_RUP:  ovf_result = sign ? max_v : inf_v;
      default: ovf_result = inf_v;
    endcase
  endfunction

  logic             vld_p1_q, vld_p1_d;
  logic             vld_p2_q, vld_p2_d;
  s1_t              stg_p1_q, stg_p1_d;
  logic [RES_W-1:0] res_p2_q, res_p2_d;
  logic [4:0]       flg_p2_q, flg_p2_d;
  logic             s1_en, s2_en, in_acc;
  logic [2:0]       eff_rm;
  logic             g_bit, r_bit, s_bit;
  logic             carry;
  logic [MAN_W-1:0] man_rnd;
  logic [EXP_W:0]   exp_rnd;
  logic             ovf;
  logic [RES_W-1:0] res_n;
  logic [4:0]       flg_n;

  assign s2_en     = ~vld_p2_q | out_ready;
  assign s1_en     = ~vld_p1_q | s2_en;
  assign in_ready  = s1_en;
  assign in_acc    = in_valid & s1_en;
  assign out_valid = vld_p2_q;
  assign out_result = res_p2_q;
  assign out_fflags = flg_p2_q;

  assign eff_rm = (in_rm == 3'b111) ? frm : in_rm;
  assign g_bit  = in_grs[GRS_W-1];
  assign r_bit  = in_grs[GRS_W-2];
  assign s_bit  = |in_grs[GRS_W-3:0];

  // ---- stage 1: rounding decision and special class ----
  always_comb begin
    vld_p1_d = vld_p1_q;
    stg_p1_d = stg_p1_q;
    if (s1_en) vld_p1_d = in_valid;
    if (in_acc) begin
      stg_p1_d.sign    = in_sign;
      stg_p1_d.exp     = in_exp;
      stg_p1_d.man     = in_man;
      stg_p1_d.rm      = eff_rm;
      stg_p1_d.up      = round_up(eff_rm, in_sign, g_bit, r_bit, s_bit, in_man[0]);
      stg_p1_d.inx     = g_bit | r_bit | s_bit;
      stg_p1_d.illegal = (eff_rm > RM_RMM);
      stg_p1_d.invalid = in_invalid;
      stg_p1_d.nan     = in_nan;
      stg_p1_d.inf     = in_inf;
      stg_p1_d.ovf     = (in_exp >= EXP_TOP);
      stg_p1_d.uflow   = in_uflow;
    end
  end

  // ---- stage 2: increment, overflow, pack ----
  always_comb begin
    {carry, man_rnd} = {1'b0, stg_p1_q.man} + {{MAN_W{1'b0}}, stg_p1_q.up};
    exp_rnd = stg_p1_q.exp + {{EXP_W{1'b0}}, carry};
    ovf     = stg_p1_q.ovf | (exp_rnd >= EXP_TOP);
    res_n   = {stg_p1_q.sign, exp_rnd[EXP_W-1:0], man_rnd};
    flg_n   = {4'b0000, stg_p1_q.inx};
    if (stg_p1_q.illegal || stg_p1_q.invalid) begin
      res_n = QNAN;
      flg_n = FLG_NV;
    end else if (stg_p1_q.nan) begin
      res_n = QNAN;
      flg_n = 5'b00000;
    end else if (stg_p1_q.inf) begin
      res_n = {stg_p1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_n = 5'b00000;
    end else if (ovf) begin
      res_n = ovf_result(stg_p1_q.rm, stg_p1_q.sign);
      flg_n = FLG_OFNX;
    end else if (stg_p1_q.uflow) begin
      res_n = {stg_p1_q.sign, {(RES_W-1){1'b0}}};
      flg_n = FLG_UFNX;
    end

    vld_p2_d = vld_p2_q;
    res_p2_d = res_p2_q;
    flg_p2_d = flg_p2_q;
    if (s2_en) vld_p2_d = vld_p1_q;
    if (s2_en && vld_p1_q) begin
      res_p2_d = res_n;
      flg_p2_d = flg_n;
    end
  end

  // Valids and the visible outputs reset; stage-1 payload does not need to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
      flg_p2_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      res_p2_q <= res_p2_d;
      flg_p2_q <= flg_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    stg_p1_q <= stg_p1_d;
  end

endmodule

// File: tb/tb_fp_round_pack_pipe.sv
// Bench for fp_round_pack_pipe (binary32): directed cases, back-pressure, reset, random stream vs reference.
module tb_fp_round_pack_pipe;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [22:0] man;
    logic [23:0] grs;
    logic        uflow;
    logic        nan;
    logic        inv;
    logic        inf;
    logic [2:0]  rm;
    logic [2:0]  frm;
  } txn_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic        in_sign;
  logic [8:0]  in_exp;
  logic [22:0] in_man;
  logic [23:0] in_grs;
  logic        in_uflow, in_nan, in_invalid, in_inf;
  logic [2:0]  in_rm, frm;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_fflags;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_out   = 0;
  logic [36:0] exp_q[$];
  logic [36:0] held;
  bit          hold_vld = 0;
  bit          rand_on  = 0;

  fp_round_pack_pipe #(.EXP_W(8), .MAN_W(23), .GRS_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_grs(in_grs),
    .in_uflow(in_uflow), .in_nan(in_nan), .in_invalid(in_invalid), .in_inf(in_inf),
    .in_rm(in_rm), .frm(frm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_fflags(out_fflags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference: value-level rounding of the tail against one half ulp.
  function automatic logic [36:0] model_ref(input txn_t t);
    int eff, tail, half, m, e;
    bit up, to_inf;
    eff = (t.rm == 3'd7) ? int'(t.frm) : int'(t.rm);
    if (eff > 4)  return {5'b10000, 32'h7FC00000};
    if (t.inv)    return {5'b10000, 32'h7FC00000};
    if (t.nan)    return {5'b00000, 32'h7FC00000};
    if (t.inf)    return {5'b00000, t.sign, 8'hFF, 23'h0};
    tail = int'(t.grs);
    half = 1 << 23;
    case (eff)
      0:       up = (tail > half) || (tail == half && t.man[0]);
      1:       up = 0;
      2:       up = t.sign && (tail != 0);
      3:       up = !t.sign && (tail != 0);
      default: up = (tail >= half);
    endcase
    m = int'(t.man) + int'(up);
    e = int'(t.exp);
    if (m == (1 << 23)) begin
      m = 0;
      e++;
    end
    if (e >= 255) begin
      to_inf = (eff == 0) || (eff == 4) || (eff == 2 && t.sign) || (eff == 3 && !t.sign);
      return to_inf ? {5'b00101, t.sign, 8'hFF, 23'h0} : {5'b00101, t.sign, 8'hFE, 23'h7FFFFF};
    end
    if (t.uflow) return {5'b00011, t.sign, 31'h0};
    return {4'b0000, (tail != 0), t.sign, e[7:0], m[22:0]};
  endfunction

  // Scoreboard: record accepted inputs, compare emitted outputs in order, check hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_vld = 0;
    end else begin
      if (hold_vld) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", {out_fflags, out_result}, held);
      end
      hold_vld = out_valid && !out_ready;
      held     = {out_fflags, out_result};
      if (out_valid && out_ready) begin
        check("out_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("stream_result", {out_fflags, out_result}, exp_q.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_ref({in_sign, in_exp, in_man, in_grs, in_uflow, in_nan,
                                   in_invalid, in_inf, in_rm, frm}));
        n_acc++;
      end
    end
  end

  task automatic apply(input txn_t t);
    in_sign = t.sign; in_exp = t.exp; in_man = t.man; in_grs = t.grs;
    in_uflow = t.uflow; in_nan = t.nan; in_invalid = t.inv; in_inf = t.inf;
    in_rm = t.rm; frm = t.frm;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
  task automatic send(input txn_t t);
    int guard;
    apply(t);
    in_valid = 1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("accept_in_time", guard < 200, 1'b1);
    @(posedge clk); #1;
  endtask

  function automatic txn_t mk(input logic s, input logic [8:0] e, input logic [22:0] m,
                              input logic [23:0] g, input logic [2:0] rm, input logic [2:0] f);
    txn_t t;
    t = '0;
    t.sign = s; t.exp = e; t.man = m; t.grs = g; t.rm = rm; t.frm = f;
    return t;
  endfunction

  task automatic dir(input string tag, input txn_t t, input logic [31:0] eres, input logic [4:0] eflg);
    send(t);
    in_valid = 0;
    check({tag, "_lat1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "_vld"}, out_valid, 1'b1);
    check({tag, "_res"}, out_result, eres);
    check({tag, "_flg"}, out_fflags, eflg);
    @(posedge clk); #1;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    int sel;
    t = '0;
    t.sign = 1'($urandom_range(0, 1));
    sel = $urandom_range(0, 9);
    if (sel < 6)       t.exp = 9'($urandom_range(1, 253));
    else if (sel == 6) t.exp = 9'h0FE;
    else if (sel == 7) t.exp = 9'h0FF;
    else if (sel == 8) t.exp = 9'($urandom_range(256, 511));
    else               t.exp = 9'h000;
    t.man = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
    case ($urandom_range(0, 4))
      0:       t.grs = 24'h000000;
      1:       t.grs = 24'h800000;
      2:       t.grs = 24'h400000;
      default: t.grs = 24'($urandom);
    endcase
    t.uflow = ($urandom_range(0, 15) == 0);
    t.nan   = ($urandom_range(0, 15) == 0);
    t.inv   = ($urandom_range(0, 15) == 0);
    t.inf   = ($urandom_range(0, 15) == 0);
    t.rm    = 3'($urandom_range(0, 7));
    t.frm   = 3'($urandom_range(0, 7));
    return t;
  endfunction

  initial begin
    txn_t sp;
    int   acc0, out0, guard;
    clk = 0;
    rst_n = 0;
    in_valid = 0;
    out_ready = 1;
    apply('0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_fflags", out_fflags, 5'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);

    dir("rne_tie_odd",  mk(0, 9'h07F, 23'h000001, 24'h800000, 3'b000, 3'b000), 32'h3F800002, 5'b00001);
    dir("rne_tie_even", mk(0, 9'h07F, 23'h000000, 24'h800000, 3'b000, 3'b000), 32'h3F800000, 5'b00001);
    dir("rne_carry",    mk(0, 9'h07F, 23'h7FFFFF, 24'h800000, 3'b000, 3'b000), 32'h40000000, 5'b00001);
    dir("ovf_rtz_pos",  mk(0, 9'h0FF, 23'h000000, 24'h000000, 3'b001, 3'b000), 32'h7F7FFFFF, 5'b00101);
    dir("ovf_rdn_neg",  mk(1, 9'h0FF, 23'h000000, 24'h000000, 3'b010, 3'b000), 32'hFF800000, 5'b00101);
    dir("ovf_rup_neg",  mk(1, 9'h0FF, 23'h000000, 24'h000000, 3'b011, 3'b000), 32'hFF7FFFFF, 5'b00101);
    dir("ovf_round",    mk(0, 9'h0FE, 23'h7FFFFF, 24'h800000, 3'b000, 3'b000), 32'h7F800000, 5'b00101);
    dir("dyn_rdn",      mk(1, 9'h07F, 23'h000000, 24'h400000, 3'b111, 3'b010), 32'hBF800001, 5'b00001);
    dir("illegal_rm",   mk(0, 9'h07F, 23'h000000, 24'h000000, 3'b101, 3'b000), 32'h7FC00000, 5'b10000);
    dir("exact_rmm",    mk(0, 9'h080, 23'h123456, 24'h000000, 3'b100, 3'b000), 32'h40123456, 5'b00000);
    sp = mk(0, 9'h07F, 23'h0, 24'h0, 3'b000, 3'b000); sp.inv = 1;
    dir("invalid",      sp, 32'h7FC00000, 5'b10000);
    sp = mk(1, 9'h07F, 23'h0, 24'h0, 3'b000, 3'b000); sp.inf = 1;
    dir("inf_neg",      sp, 32'hFF800000, 5'b00000);
    sp = mk(1, 9'h001, 23'h0, 24'h0, 3'b000, 3'b000); sp.uflow = 1;
    dir("uflow_neg",    sp, 32'h80000000, 5'b00011);

    // Back-pressure: consumer stalls for five cycles against four back-to-back inputs.
    acc0 = n_acc;
    out0 = n_out;
    out_ready = 0;
    fork
      begin
        send(mk(0, 9'h080, 23'h000011, 24'h000000, 3'b000, 3'b000));
        send(mk(0, 9'h080, 23'h000022, 24'h000000, 3'b000, 3'b000));
        send(mk(1, 9'h080, 23'h000033, 24'hC00000, 3'b000, 3'b000));
        send(mk(1, 9'h080, 23'h000044, 24'h000001, 3'b011, 3'b000));
        in_valid = 0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_two_accepted", n_acc - acc0, 2);
      end
    join
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("bp_drained", exp_q.size(), 0);
    check("bp_four_out", n_out - out0, 4);

    // Reset with two transactions in flight.
    send(mk(0, 9'h081, 23'h000055, 24'h000000, 3'b000, 3'b000));
    send(mk(0, 9'h081, 23'h000066, 24'h000000, 3'b000, 3'b000));
    in_valid = 0;
    out0 = n_out;
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    check("arst_no_emit", n_out - out0, 0);
    check("arst_idle", out_valid, 1'b0);

    // Random stream with bubbles and random consumer stalls.
    acc0 = n_acc;
    rand_on = 1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 0;
            @(posedge clk); #1;
          end
          send(rand_txn());
        end
        in_valid = 0;
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rand_accepted", n_acc - acc0, 300);
    check("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
